// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared widths, FSM state encoding and address field helpers
//               for the direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Upper address bits identify which block occupies a line
  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  // Middle address bits select the line
  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  // Low address bits select the byte within the block
  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_cpu_if / dcache_mem_if
// Description : CPU-side byte handshake and memory-side block handshake of the
//               data cache. master = requester, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_cpu_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              busy_wait;

  modport master (output read, write, address, write_data,
                  input  read_data, busy_wait);
  modport slave  (input  read, write, address, write_data,
                  output read_data, busy_wait);
endinterface

interface dcache_mem_if #(
  parameter int MADDR_W = 6,
  parameter int BLOCK_W = 32
);
  logic               mem_read;
  logic               mem_write;
  logic [MADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (output mem_read, mem_write, mem_address, mem_writedata,
                  input  mem_readdata, mem_busywait);
  modport slave  (input  mem_read, mem_write, mem_address, mem_writedata,
                  output mem_readdata, mem_busywait);
endinterface
`default_nettype wire

// File: rtl/data_cache_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dcache_fsm
// Description : Miss-handling controller: IDLE -> [WRITEBACK] -> FETCH ->
//               UPDATE -> IDLE. Memory strobes are registered; the CPU stall
//               in IDLE is combinational so hits never stall.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_fsm
  import dcache_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_request,
  input  wire logic i_hit,
  input  wire logic i_dirty,
  input  wire logic i_mem_busywait,
  output state_t    o_state,
  output logic      o_busy_wait,
  output logic      o_mem_read,
  output logic      o_mem_write,
  output logic      o_fill_en
);

  state_t r_state;
  logic   r_mem_read;
  logic   r_mem_write;

  // State register and registered memory strobes; strobes change on the same
  // edge as the state so they always match it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_request && !i_hit) begin
            if (i_dirty) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!i_mem_busywait) begin
            r_state     <= FETCH;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
          end
        end
        FETCH: begin
          if (!i_mem_busywait) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Stall: only a missing request stalls in IDLE; every other state stalls.
  // Held low while reset is asserted so an outstanding request cannot stall.
  always_comb begin
    o_busy_wait = 1'b0;
    if (rst) begin
      o_busy_wait = (r_state == IDLE) ? (i_request && !i_hit) : 1'b1;
    end
  end

  assign o_fill_en   = (r_state == FETCH) && !i_mem_busywait;
  assign o_state     = r_state;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-back, write-allocate data cache with
//               byte CPU access and 4-byte block memory transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int ADDR_W   = dcache_pkg::ADDR_W,
  parameter int DATA_W   = dcache_pkg::DATA_W,
  parameter int INDEX_W  = dcache_pkg::INDEX_W,
  parameter int OFFSET_W = dcache_pkg::OFFSET_W
) (
  input  wire logic    clk,
  input  wire logic    rst,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int BLOCK_W = DATA_W << OFFSET_W;
  localparam int LSB_W   = $clog2(BLOCK_W);

  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [LSB_W-1:0]    w_lsb;
  logic                w_hit;
  logic                w_request;
  logic                w_line_dirty;
  logic                w_idle;
  logic                w_rd_hit;
  logic                w_wr_hit;
  logic                w_fill_en;
  logic                w_busy_wait;
  logic                w_mem_read;
  logic                w_mem_write;
  dcache_pkg::state_t  w_state;

  assign w_tag     = cpu.address[ADDR_W-1 -: TAG_W];
  assign w_index   = cpu.address[OFFSET_W +: INDEX_W];
  assign w_offset  = cpu.address[OFFSET_W-1:0];
  assign w_lsb     = LSB_W'(w_offset) * LSB_W'(DATA_W);

  // Simultaneous read and write is illegal and treated as no request
  assign w_request    = cpu.read ^ cpu.write;
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_idle       = (w_state == dcache_pkg::IDLE);
  assign w_rd_hit     = w_idle && cpu.read && !cpu.write && w_hit;
  assign w_wr_hit     = w_idle && cpu.write && !cpu.read && w_hit;

  dcache_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .i_request      (w_request),
    .i_hit          (w_hit),
    .i_dirty        (w_line_dirty),
    .i_mem_busywait (mem.mem_busywait),
    .o_state        (w_state),
    .o_busy_wait    (w_busy_wait),
    .o_mem_read     (w_mem_read),
    .o_mem_write    (w_mem_write),
    .o_fill_en      (w_fill_en)
  );

  // Line status: a fill makes the line valid and clean, a store hit dirties it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_en) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; validity alone guards them
  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem.mem_readdata;
    end else if (w_wr_hit) begin
      r_data[w_index][w_lsb +: DATA_W] <= cpu.write_data;
    end
  end

  // Load data is returned in the hit cycle, zero otherwise
  always_comb begin
    cpu.read_data = '0;
    if (w_rd_hit) begin
      cpu.read_data = r_data[w_index][w_lsb +: DATA_W];
    end
  end

  // Block address/data follow the state: evicted block in WRITEBACK,
  // requested block in FETCH, idle-zero otherwise
  always_comb begin
    mem.mem_address   = '0;
    mem.mem_writedata = '0;
    case (w_state)
      dcache_pkg::WRITEBACK: begin
        mem.mem_address   = {r_tag[w_index], w_index};
        mem.mem_writedata = r_data[w_index];
      end
      dcache_pkg::FETCH: begin
        mem.mem_address = cpu.address[ADDR_W-1:OFFSET_W];
      end
      default: begin
        mem.mem_address   = '0;
        mem.mem_writedata = '0;
      end
    endcase
  end

  assign cpu.busy_wait = w_busy_wait;
  assign mem.mem_read  = w_mem_read;
  assign mem.mem_write = w_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Directed self-checking bench for data_cache with a 5-cycle
//               block memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;
  import dcache_pkg::*;

  localparam int MEM_LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_cpu_if cpu ();
  dcache_mem_if mem ();

  data_cache dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .mem (mem)
  );

  // Block memory model
  logic [31:0] mem_blk [64];
  bit          init_done = 1'b0;
  int          lat_cnt   = 0;
  int          rd_count  = 0;
  int          wr_count  = 0;
  logic [5:0]  last_rd_addr  = '0;
  logic [5:0]  last_wr_addr  = '0;
  logic [31:0] last_wr_data  = '0;

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      6'h04:   return 32'hDDCCBBAA;
      6'h24:   return 32'h87654321;
      6'h0B:   return 32'h44332211;
      default: return {b + 8'h30, b + 8'h20, b + 8'h10, b + 8'h80};
    endcase
  endfunction

  assign mem.mem_busywait = (mem.mem_read | mem.mem_write) && (lat_cnt < MEM_LAT - 1);
  assign mem.mem_readdata = mem_blk[mem.mem_address];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem_blk[i] <= init_val(i);
      init_done <= 1'b1;
    end else if ((mem.mem_read | mem.mem_write) && !mem.mem_busywait) begin
      lat_cnt <= 0;
      if (mem.mem_write) begin
        mem_blk[mem.mem_address] <= mem.mem_writedata;
        wr_count     <= wr_count + 1;
        last_wr_addr <= mem.mem_address;
        last_wr_data <= mem.mem_writedata;
      end else begin
        rd_count     <= rd_count + 1;
        last_rd_addr <= mem.mem_address;
      end
    end else if (mem.mem_read | mem.mem_write) begin
      lat_cnt <= lat_cnt + 1;
    end else begin
      lat_cnt <= 0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; counts stalled cycles and captures data in the hit cycle
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int busy_cyc,
                        output logic [7:0] rdata);
    cpu.read       = rd;
    cpu.write      = wr;
    cpu.address    = a;
    cpu.write_data = wd;
    busy_cyc = 0;
    rdata    = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu.busy_wait) busy_cyc++;
      else begin
        rdata = cpu.read_data;
        break;
      end
    end
    @(posedge clk); #1;
    cpu.read  = 1'b0;
    cpu.write = 1'b0;
  endtask

  initial begin
    int         bc;
    logic [7:0] rd;
    int         rc0, wc0;

    cpu.read = 1'b0; cpu.write = 1'b0; cpu.address = '0; cpu.write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(cpu.busy_wait),     32'h0);
    check("rst_mrd",    32'(mem.mem_read),      32'h0);
    check("rst_mwr",    32'(mem.mem_write),     32'h0);
    check("rst_rdata",  32'(cpu.read_data),     32'h0);
    check("rst_maddr",  32'(mem.mem_address),   32'h0);
    check("rst_mwdata", mem.mem_writedata,      32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Clean read miss on invalid line 4
    rc0 = rd_count;
    access(1'b1, 1'b0, 8'h13, 8'h00, bc, rd);
    check("miss13_busy",  32'(bc), 32'd7);
    check("miss13_data",  32'(rd), 32'hDD);
    check("miss13_nrd",   32'(rd_count - rc0), 32'd1);
    check("miss13_maddr", 32'(last_rd_addr), 32'({get_tag(8'h13), get_index(8'h13)}));

    // Read hit
    access(1'b1, 1'b0, 8'h12, 8'h00, bc, rd);
    check("hit12_busy", 32'(bc), 32'd0);
    check("hit12_data", 32'(rd), 32'hCC);

    // Write hit dirties line 4 without memory traffic
    wc0 = wr_count;
    access(1'b0, 1'b1, 8'h10, 8'h11, bc, rd);
    check("wrhit10_busy", 32'(bc), 32'd0);
    check("wrhit10_nwr",  32'(wr_count - wc0), 32'd0);

    // Conflict miss on dirty line 4: writeback then fetch
    wc0 = wr_count; rc0 = rd_count;
    access(1'b1, 1'b0, 8'h90, 8'h00, bc, rd);
    check("miss90_busy",   32'(bc), 32'd12);
    check("miss90_nwr",    32'(wr_count - wc0), 32'd1);
    check("miss90_wraddr", 32'(last_wr_addr), 32'h04);
    check("miss90_wrdata", last_wr_data, 32'hDDCCBB11);
    check("miss90_rdaddr", 32'(last_rd_addr), 32'h24);
    check("miss90_data",   32'(rd), 32'h21);

    // Line 4 now clean: miss back to 0x10 fetches the written-back byte
    wc0 = wr_count;
    access(1'b1, 1'b0, 8'h10, 8'h00, bc, rd);
    check("miss10_busy", 32'(bc), 32'd7);
    check("miss10_data", 32'(rd), 32'h11);
    check("miss10_nwr",  32'(wr_count - wc0), 32'd0);

    // Write miss allocates line 3 and merges the byte
    access(1'b0, 1'b1, 8'h2F, 8'h5A, bc, rd);
    check("wmiss2F_busy",   32'(bc), 32'd7);
    check("wmiss2F_rdaddr", 32'(last_rd_addr), 32'h0B);
    access(1'b1, 1'b0, 8'h2F, 8'h00, bc, rd);
    check("hit2F_busy", 32'(bc), 32'd0);
    check("hit2F_data", 32'(rd), 32'h5A);

    // Evicting line 3 proves it was left dirty with the merged block
    wc0 = wr_count;
    access(1'b1, 1'b0, 8'h4F, 8'h00, bc, rd);
    check("miss4F_busy",   32'(bc), 32'd12);
    check("miss4F_nwr",    32'(wr_count - wc0), 32'd1);
    check("miss4F_wraddr", 32'(last_wr_addr), 32'h0B);
    check("miss4F_wrdata", last_wr_data, 32'h5A332211);
    check("miss4F_data",   32'(rd), 32'h43);

    // Reset asserted mid-fetch
    cpu.read = 1'b1; cpu.write = 1'b0; cpu.address = 8'h00;
    @(posedge clk); #1;
    check("fetch0_mrd", 32'(mem.mem_read), 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rstmid_mrd",   32'(mem.mem_read),    32'h0);
    check("rstmid_busy",  32'(cpu.busy_wait),   32'h0);
    check("rstmid_maddr", 32'(mem.mem_address), 32'h0);
    cpu.read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 8'h12, 8'h00, bc, rd);
    check("postrst12_busy", 32'(bc), 32'd7);
    check("postrst12_data", 32'(rd), 32'hCC);

    // Illegal read+write: no stall, no memory request, no allocation
    cpu.read = 1'b1; cpu.write = 1'b1; cpu.address = 8'h00; cpu.write_data = 8'hEE;
    @(negedge clk);
    check("illegal_busy",  32'(cpu.busy_wait), 32'h0);
    check("illegal_rdata", 32'(cpu.read_data), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_mrd", 32'(mem.mem_read),  32'h0);
    check("illegal_mwr", 32'(mem.mem_write), 32'h0);
    @(posedge clk); #1;
    cpu.read = 1'b0; cpu.write = 1'b0;
    access(1'b1, 1'b0, 8'h00, 8'h00, bc, rd);
    check("after_ill00_busy", 32'(bc), 32'd7);
    check("after_ill00_data", 32'(rd), 32'h80);
    access(1'b1, 1'b0, 8'h12, 8'h00, bc, rd);
    check("after_ill12_busy", 32'(bc), 32'd0);
    check("after_ill12_data", 32'(rd), 32'hCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
